// File: rtl/multiplicador_if.sv
`default_nettype none
// ============================================================================
// Module   : multiplicador_if
// Purpose  : Handshake and operand bundle for the shift-and-add multiplier.
//            The master drives the request and operands, and the slave
//            returns the result and status.
// Signals  : start - request, sampled only while the multiplier is idle
//            A     - multiplicand, unsigned, WIDTH bits
//            B     - multiplier, unsigned, WIDTH bits
//            C     - addend, unsigned, WIDTH bits (tie to 0 for a plain multiply)
//            P     - result A*B+C, 2*WIDTH bits; holds the last completed result
//            busy  - high while iterating
//            done  - one-cycle pulse when P is updated
// Revision : 1.0 - initial release
// ============================================================================
interface multiplicador_if #(
  parameter int WIDTH = 4
);
  logic               start;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [WIDTH-1:0]   C;
  logic [2*WIDTH-1:0] P;
  logic               busy;
  logic               done;

  modport master (output start, A, B, C, input  P, busy, done);
  modport slave  (input  start, A, B, C, output P, busy, done);
endinterface
`default_nettype wire

// File: rtl/multiplicador.sv
`default_nettype none
// ============================================================================
// Module   : multiplicador
// Purpose  : Sequential shift-and-add multiplier that computes P = A*B + C
//            on unsigned operands. It forms one partial product per clock,
//            so the latency is fixed at WIDTH cycles from start to done.
//            When it is fed a divider's quotient, divisor and remainder, it
//            rebuilds the original dividend.
// Ports    : clk   - rising-edge clock
//            reset - asynchronous active-low reset
//            bus   - multiplicador_if.slave (start/A/B/C in, P/busy/done out)
// Revision : 1.0 - initial release
// ============================================================================
module multiplicador #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  multiplicador_if.slave bus
);

  localparam int              c_PW   = 2 * WIDTH;
  localparam int              c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [c_PW-1:0]  r_acc;
  logic [c_PW-1:0]  r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [c_CW-1:0]  r_count;
  logic [c_PW-1:0]  r_p;
  logic             r_busy;
  logic             r_done;

  // The accumulator value after this cycle's partial product. It is also the
  // final result on the last iteration, so P is loaded on the same edge.
  // The accumulator never overflows: the largest result is 2^2W - 2^W.
  logic [c_PW-1:0]  w_acc_next;
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_p      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            // Operands are captured here, so later changes on A/B/C have
            // no effect on the operation in progress.
            r_acc    <= {{WIDTH{1'b0}}, bus.C};
            r_mcand  <= {{WIDTH{1'b0}}, bus.A};
            r_mplier <= bus.B;
            r_count  <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_CALC;
          end
        end

        S_CALC: begin
          // All WIDTH iterations always run. The loop does not end early
          // when the multiplier becomes zero, which keeps the latency fixed.
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + 1'b1;
          if (r_count == c_LAST) begin
            r_p     <= w_acc_next;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          // A start seen here is dropped rather than queued.
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.P    = r_p;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule
`default_nettype wire
